forward_scoreboard: RTL
=======================

Name: forward_scoreboard

Overview:
Parametrised forwarding and hazard unit for the deeper MIPS pipeline. It replaces pure combinational EX-stage forwarding with a tag scoreboard evaluated in ID. Each cycle it tracks in-flight register producers through DEPTH stages, selects the youngest ready producer for each source operand, and inserts load-use bubbles. It also tracks multi-cycle mul/div occupancy so that HI/LO consumers wait.

Parameters:
NSRC, 2, number of source operands checked per ID instruction
DEPTH, 3, tracked stages after ID (index 0 = EX, 1 = MEM, 2 = WB)
WORD_W, 32, data width
REG_W, 5, register index width
LOAD_READY, 2, lowest stage index at which load data is forwardable
MD_LAT, 4, mul/div busy cycles after issue

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  ID holds a valid instruction that wants to enter EX
issue_wreg  in  REG_W  destination register of the ID instruction (0 = none)
issue_kind  in  2  producer kind: 0 ALU, 1 LOAD, 2 LINK, 3 MULDIV
src_reg  in  NSRC*REG_W  source register indices of the ID instruction, flattened
src_use  in  NSRC  per-source "operand actually read"
src_hilo  in  1  ID instruction reads HI/LO or starts mul/div
flush  in  1  squash all in-flight entries (branch/exception)
stage_data  in  DEPTH*WORD_W  result value at each tracked stage (ALU out, link PC, or load data)
stall  out  1  hold PC/IF/ID; bubble into EX
fwd  out  NSRC  per-source forward valid
fwd_data  out  NSRC*WORD_W  per-source forwarded value
md_busy  out  1  mul/div counter non-zero

Behaviour:
- Reset (async): all entries invalid, md_cnt = 0. Outputs are therefore stall = 0, fwd = 0, fwd_data = 0, md_busy = 0.
- Entry i holds {valid, wreg, kind}. Entries are created only when issue_wreg != 0; MULDIV entries carry wreg = 0 (HI/LO are tracked by md_cnt).
- Shift on each clk:
  - entry[i] <= entry[i-1] for i >= 1, always, regardless of stall.
  - entry[0] <= issue entry if issue_valid && !stall && !flush; otherwise a bubble.
  - entry[DEPTH-1] retires.
- flush: on the next edge, entries 0..DEPTH-1 become invalid. md_cnt is not affected because the mul/div unit cannot abort. flush has priority over issue.
- Ready rule: entry i is ready if kind is ALU or LINK (any i), or kind is LOAD and i >= LOAD_READY.
- Match for source s: requires src_use[s], src_reg[s] != 0, and valid entry with wreg == src_reg[s]. The youngest match (lowest i) wins; older matches are ignored.
  - Youngest match ready: fwd[s] = 1, fwd_data[s] = stage_data[i].
  - Youngest match not ready: fwd[s] = 0, and a stall is requested.
  - No match: fwd[s] = 0, fwd_data[s] = 0.
- stall = issue_valid && (any source matches a not-ready entry, or src_hilo && md_cnt != 0). stall, fwd and fwd_data are combinational in the current cycle.
- md_cnt:
  - Loads MD_LAT on an accepted MULDIV issue.
  - Otherwise decrements while non-zero and saturates at 0.
  - md_busy = (md_cnt != 0).
- A source matching both operand slots forwards identically on both.
- Load-use with LOAD_READY = 2 gives exactly 2 stall cycles; ALU-use gives 0.
- Reset asserted mid-stall clears stall in the same cycle (asynchronous), with no residual bubble.

Optional Feature:
FWD_STATS_EN:
- When defined, adds outputs stat_stall (32-bit) and stat_fwd (32-bit), both reset to 0 and saturating at 0xFFFFFFFF.
  - stat_stall increments on each cycle with stall = 1.
  - stat_fwd increments by popcount(fwd) per cycle while issue_valid && !stall.
- When not defined, these ports and counters are absent, and the core behaviour is identical.

Test Plan:
- ALU-use: issue addu wreg = 8 (ALU); next cycle ID src_reg[0] = 8 with stage_data[0] = 0x00000011 -> stall = 0, fwd[0] = 1, fwd_data[0] = 0x00000011.
- Load-use: issue lw wreg = 9; next ID reads $9 -> stall = 1 for 2 cycles. Third cycle fwd[0] = 1, fwd_data = stage_data[2] = 0xDEADBEEF. Entry[0] holds bubbles during the stalls.
- Priority: ALU wreg = 5 in MEM with stage_data[1] = 1, ALU wreg = 5 in EX with stage_data[0] = 2, ID reads $5 in both sources -> fwd = 2'b11, both fwd_data = 2.
- Zero/unused: ID src_reg = 0 while entry wreg = 0; src_use[1] = 0 with a matching entry -> fwd = 0, stall = 0.
- Mul/div: accepted MULDIV issue, then mfhi (src_hilo = 1) -> md_busy = 1, stall = 1 for exactly 4 cycles, then stall = 0.
- Flush/reset: flush while lw wreg = 9 is in EX and ID reads $9 -> next cycle no match, stall = 0. Asserting reset mid-mul/div gives md_busy = 0 immediately.

Source files
------------

// File: rtl/forward_scoreboard.sv
// ---------------------------------------------------------------------------
// forward_scoreboard
//
// Forwarding and hazard unit evaluated in ID. It keeps a small shift register
// of in-flight register producers (index 0 = EX, 1 = MEM, 2 = WB). For each
// source operand it picks the youngest matching producer. If that producer is
// ready, its stage value is forwarded. If it is not ready (a load still
// before LOAD_READY), ID is stalled. A mul/div occupancy counter makes HI/LO
// consumers wait until the unit is done.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   issue_valid  ID holds a valid instruction that wants to enter EX
//   issue_wreg   destination register of the ID instruction (0 = none)
//   issue_kind   producer kind: 0 ALU, 1 LOAD, 2 LINK, 3 MULDIV
//   src_reg      flattened source register indices (NSRC x REG_W)
//   src_use      per-source "operand actually read"
//   src_hilo     ID instruction reads HI/LO or starts a mul/div
//   flush        squash all in-flight entries on the next edge
//   stage_data   flattened result value at each tracked stage
//   stall        hold PC/IF/ID and inject a bubble into EX (combinational)
//   fwd          per-source forward valid (combinational)
//   fwd_data     per-source forwarded value, 0 when no match (combinational)
//   md_busy      mul/div occupancy counter is non-zero
//
// Optional feature, enabled by defining the macro FWD_STATS_EN:
//   stat_stall   saturating count of cycles with stall = 1
//   stat_fwd     saturating count of forwarded operands on accepted issues
//
// Handshake: an ID instruction is accepted into EX on a rising edge when
// issue_valid = 1, stall = 0 and flush = 0. Otherwise a bubble enters EX.
// ---------------------------------------------------------------------------
module forward_scoreboard #(
    parameter int NSRC       = 2,
    parameter int DEPTH      = 3,
    parameter int WORD_W     = 32,
    parameter int REG_W      = 5,
    parameter int LOAD_READY = 2,
    parameter int MD_LAT     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic [REG_W-1:0]        issue_wreg,
    input  logic [1:0]              issue_kind,
    input  logic [NSRC*REG_W-1:0]   src_reg,
    input  logic [NSRC-1:0]         src_use,
    input  logic                    src_hilo,
    input  logic                    flush,
    input  logic [DEPTH*WORD_W-1:0] stage_data,
    output logic                    stall,
    output logic [NSRC-1:0]         fwd,
    output logic [NSRC*WORD_W-1:0]  fwd_data,
    output logic                    md_busy
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]             stat_stall,
    output logic [31:0]             stat_fwd
`endif
);

    localparam logic [1:0] KIND_ALU    = 2'd0;
    localparam logic [1:0] KIND_LOAD   = 2'd1;
    localparam logic [1:0] KIND_LINK   = 2'd2;
    localparam logic [1:0] KIND_MULDIV = 2'd3;

    localparam int MD_W = $clog2(MD_LAT + 1);

    // Producer entries, index 0 is the youngest (EX).
    logic [DEPTH-1:0] ent_valid;
    logic [REG_W-1:0] ent_wreg [DEPTH];
    logic [1:0]       ent_kind [DEPTH];
    logic [DEPTH-1:0] ent_ready;

    logic [MD_W-1:0]  md_cnt;

    logic [NSRC-1:0]  hazard;
    logic             accept;

    // Scratch values for the per-source search.
    logic              hit;
    logic              hit_ready;
    logic [WORD_W-1:0] hit_data;

    // A load only has its data from stage LOAD_READY onward. ALU and LINK
    // results exist from EX. MULDIV entries are never valid, so their kind
    // does not matter here.
    always_comb begin
        ent_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_ready[i] = (ent_kind[i] != KIND_LOAD) || (i >= LOAD_READY);
        end
    end

    // Youngest-match search: scan from oldest to youngest so that the
    // last hit seen is the youngest producer.
    always_comb begin
        fwd       = '0;
        fwd_data  = '0;
        hazard    = '0;
        hit       = 1'b0;
        hit_ready = 1'b0;
        hit_data  = '0;
        for (int s = 0; s < NSRC; s++) begin
            hit       = 1'b0;
            hit_ready = 1'b0;
            hit_data  = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (ent_valid[i] && (ent_wreg[i] == src_reg[s*REG_W +: REG_W])) begin
                    hit       = 1'b1;
                    hit_ready = ent_ready[i];
                    hit_data  = stage_data[i*WORD_W +: WORD_W];
                end
            end
            if (src_use[s] && (src_reg[s*REG_W +: REG_W] != '0) && hit) begin
                if (hit_ready) begin
                    fwd[s]                      = 1'b1;
                    fwd_data[s*WORD_W +: WORD_W] = hit_data;
                end else begin
                    hazard[s] = 1'b1;
                end
            end
        end
    end

    assign stall   = issue_valid && ((|hazard) || (src_hilo && (md_cnt != '0)));
    assign accept  = issue_valid && !stall && !flush;
    assign md_busy = (md_cnt != '0);

    // The pipeline advances every cycle. A stall only replaces the new
    // EX entry with a bubble, and a flush invalidates everything that
    // lands in the register on this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_wreg[i] <= '0;
                ent_kind[i] <= KIND_ALU;
            end
        end else begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                ent_valid[i] <= ent_valid[i-1] && !flush;
                ent_wreg[i]  <= ent_wreg[i-1];
                ent_kind[i]  <= ent_kind[i-1];
            end
            // MULDIV writes HI/LO, which md_cnt tracks, so no GPR entry is made.
            ent_valid[0] <= accept && (issue_kind != KIND_MULDIV) && (issue_wreg != '0);
            ent_wreg[0]  <= (issue_kind == KIND_MULDIV) ? '0 : issue_wreg;
            ent_kind[0]  <= issue_kind;
        end
    end

    // The mul/div unit cannot abort, so flush does not touch md_cnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (accept && (issue_kind == KIND_MULDIV)) begin
            md_cnt <= MD_W'(MD_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] fwd_pop;
    logic [32:0] fwd_sum;

    always_comb begin
        fwd_pop = '0;
        for (int s = 0; s < NSRC; s++) begin
            fwd_pop = fwd_pop + 32'(fwd[s]);
        end
        fwd_sum = {1'b0, stat_fwd} + {1'b0, fwd_pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_stall <= '0;
            stat_fwd   <= '0;
        end else begin
            if (stall && (stat_stall != 32'hFFFF_FFFF)) begin
                stat_stall <= stat_stall + 32'd1;
            end
            if (issue_valid && !stall) begin
                stat_fwd <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
            end
        end
    end
`endif

    // KIND_LINK is listed for completeness; LINK behaves exactly like ALU.
    logic unused_kind;
    assign unused_kind = (KIND_LINK == 2'd2);

endmodule
